alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 46 ++++
 rtl/alu_arbiter.sv | 85 ++++++++
 tb/tb_alu_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two ALU requesters, the arbiter, the shared combinational ALU and the
// response consumer. The slave modport is the arbiter's view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ready;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU, with a single
// registered response slot that can stream one result per cycle.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             pri;
  logic             gnt_vld;
  logic             gnt_id;
  logic             can_accept;
  logic             accept;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_id_q;

  // Lone requester wins outright; on contention the priority bit decides.
  always_comb begin
    gnt_vld    = bus.req0_valid | bus.req1_valid;
    gnt_id     = (bus.req0_valid & bus.req1_valid) ? pri : bus.req1_valid;
    can_accept = (state == EMPTY) | bus.rsp_ready;
    accept     = reset_n & gnt_vld & can_accept;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)                          state_nxt = FULL;
    else if (state == FULL && bus.rsp_ready) state_nxt = EMPTY;
  end

  // ALU operands are forced to zero unless an operation is actually being accepted.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    if (accept) begin
      if (gnt_id) begin
        sel_op = bus.req1_op;
        sel_a  = bus.req1_a;
        sel_b  = bus.req1_b;
      end else begin
        sel_op = bus.req0_op;
        sel_a  = bus.req0_a;
        sel_b  = bus.req0_b;
      end
    end
    bus.req0_ready = accept & ~gnt_id;
    bus.req1_ready = accept &  gnt_id;
    bus.alu_op     = sel_op;
    bus.alu_a      = sel_a;
    bus.alu_b      = sel_b;
    bus.rsp_valid  = (state == FULL);
    bus.rsp_id     = rsp_id_q;
    bus.rsp_data   = rsp_data_q;
  end

  // Result capture; the non-granted requester becomes favoured after every accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      pri        <= 1'b0;
    end else if (accept) begin
      rsp_data_q <= bus.alu_out;
      rsp_id_q   <= gnt_id;
      pri        <= ~gnt_id;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand sequences for reset/contention/streaming,
// and a randomized run against a queue-based reference model.
module tb_alu_arbiter;

  localparam int W = 32;
  localparam int OW = 4;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_LT = 4'd2, OP_XOR = 4'd3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  alu_arbiter_if #(.WIDTH(W), .OPW(OW)) bus ();

  alu_arbiter #(.WIDTH(W), .OPW(OW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] alu_fn(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return {31'd0, ($signed(a) < $signed(b))};
      4'd3:    return a ^ b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      default: return a;
    endcase
  endfunction

  // Shared combinational ALU stand-in
  always_comb bus.alu_out = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  typedef struct {
    logic           v0, v1;
    logic [OW-1:0]  op0;
    logic [W-1:0]   a0, b0;
    logic [OW-1:0]  op1;
    logic [W-1:0]   a1, b1;
    logic           rr;
    logic           e_r0, e_r1, e_rv, e_id;
    logic [W-1:0]   e_data;
  } vec_t;

  typedef struct {
    logic         id;
    logic [W-1:0] d;
  } rsp_t;

  vec_t tbl[11];
  rsp_t q[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [OW-1:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                              input logic v1, input logic [OW-1:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                              input logic rr, input logic e_r0, input logic e_r1, input logic e_rv, input logic e_id,
                              input logic [W-1:0] e_data);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.rr = rr; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_rv = e_rv; v.e_id = e_id; v.e_data = e_data;
    return v;
  endfunction

  task automatic drive(input logic v0, input logic [OW-1:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic [OW-1:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic rr);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready  = rr;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // Leaves time at posedge+1 with reset released
  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic check_alu(input string tag, input logic e_r0, input logic e_r1,
                           input logic [OW-1:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [OW-1:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    logic [OW-1:0] eop;
    logic [W-1:0]  ea, eb;
    eop = '0; ea = '0; eb = '0;
    if (e_r0) begin eop = op0; ea = a0; eb = b0; end
    if (e_r1) begin eop = op1; ea = a1; eb = b1; end
    chk({tag, " alu_op"}, W'(bus.alu_op), W'(eop));
    chk({tag, " alu_a"},  bus.alu_a, ea);
    chk({tag, " alu_b"},  bus.alu_b, eb);
  endtask

  initial begin
    logic         pend0, pend1, pri_m, rr, can, er0, er1;
    logic [OW-1:0] op0, op1;
    logic [W-1:0]  a0, b0, a1, b1;
    string         tag;

    // Directed table, applied straight after reset (pri=0, response empty)
    tbl[0]  = mk(1, OP_ADD, 5, 7,   0, OP_SUB, 0, 0,    1, 1, 0, 1, 0, 32'd12);
    tbl[1]  = mk(1, OP_ADD, 1, 2,   1, OP_SUB, 10, 3,   1, 0, 1, 1, 1, 32'd7);
    tbl[2]  = mk(1, OP_ADD, 1, 2,   1, OP_SUB, 10, 3,   1, 1, 0, 1, 0, 32'd3);
    tbl[3]  = mk(1, OP_ADD, 1, 2,   1, OP_SUB, 10, 3,   1, 0, 1, 1, 1, 32'd7);
    tbl[4]  = mk(1, OP_ADD, 1, 2,   1, OP_SUB, 10, 3,   0, 0, 0, 1, 1, 32'd7);
    tbl[5]  = mk(1, OP_ADD, 1, 2,   1, OP_SUB, 10, 3,   0, 0, 0, 1, 1, 32'd7);
    tbl[6]  = mk(1, OP_ADD, 1, 2,   1, OP_SUB, 10, 3,   0, 0, 0, 1, 1, 32'd7);
    tbl[7]  = mk(1, OP_ADD, 1, 2,   1, OP_SUB, 10, 3,   1, 1, 0, 1, 0, 32'd3);
    tbl[8]  = mk(0, OP_ADD, 0, 0,   0, OP_SUB, 0, 0,    1, 0, 0, 0, 0, 32'd0);
    tbl[9]  = mk(0, OP_ADD, 0, 0,   1, OP_XOR, 32'hF0F0, 32'h0FF0, 1, 0, 1, 1, 1, 32'h0000FF00);
    tbl[10] = mk(1, OP_LT, 32'hFFFFFFFF, 32'd1, 0, OP_ADD, 0, 0, 1, 1, 0, 1, 0, 32'd1);

    // Reset state, with both requesters pushing during reset
    drive(1'b1, OP_ADD, 32'h11, 32'h22, 1'b1, OP_SUB, 32'h33, 32'h44, 1'b1);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst rsp_valid", W'(bus.rsp_valid), 0);
    chk("rst rsp_id", W'(bus.rsp_id), 0);
    chk("rst rsp_data", bus.rsp_data, 0);
    chk("rst req0_ready", W'(bus.req0_ready), 0);
    chk("rst req1_ready", W'(bus.req1_ready), 0);
    check_alu("rst", 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    do_reset();

    foreach (tbl[i]) begin
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
      #1;
      chk({tag, " req0_ready"}, W'(bus.req0_ready), W'(tbl[i].e_r0));
      chk({tag, " req1_ready"}, W'(bus.req1_ready), W'(tbl[i].e_r1));
      check_alu(tag, tbl[i].e_r0, tbl[i].e_r1, tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].op1, tbl[i].a1, tbl[i].b1);
      @(posedge clock); #1;
      chk({tag, " rsp_valid"}, W'(bus.rsp_valid), W'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        chk({tag, " rsp_id"}, W'(bus.rsp_id), W'(tbl[i].e_id));
        chk({tag, " rsp_data"}, bus.rsp_data, tbl[i].e_data);
      end
    end

    // Contention right after reset: grants alternate 0,1,0,1
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, OP_ADD, 32'd100, 32'd20, 1'b1, OP_SUB, 32'd10, 32'd3, 1'b1);
      #1;
      chk($sformatf("cont%0d req0_ready", k), W'(bus.req0_ready), W'((k % 2) == 0));
      chk($sformatf("cont%0d req1_ready", k), W'(bus.req1_ready), W'((k % 2) == 1));
      @(posedge clock); #1;
      chk($sformatf("cont%0d rsp_id", k), W'(bus.rsp_id), W'(k % 2));
      chk($sformatf("cont%0d rsp_data", k), bus.rsp_data, ((k % 2) == 1) ? 32'd7 : 32'd120);
    end

    // Streaming: req1 continuously valid, one result per cycle
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, '0, '0, '0, 1'b1, OP_ADD, W'(k), 32'd100, 1'b1);
      #1;
      chk($sformatf("strm%0d req1_ready", k), W'(bus.req1_ready), 1);
      @(posedge clock); #1;
      chk($sformatf("strm%0d rsp_valid", k), W'(bus.rsp_valid), 1);
      chk($sformatf("strm%0d rsp_data", k), bus.rsp_data, W'(k + 100));
    end

    // Reset in the middle of a held result
    do_reset();
    drive(1'b1, OP_ADD, 32'hDEADBEEF, 32'd0, 1'b0, '0, '0, '0, 1'b0);
    @(posedge clock); #1;
    idle();
    chk("midrst held data", bus.rsp_data, 32'hDEADBEEF);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst rsp_valid", W'(bus.rsp_valid), 0);
    chk("midrst rsp_data", bus.rsp_data, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    drive(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, OP_SUB, 32'd5, 32'd1, 1'b1);
    #1;
    chk("midrst req0_ready", W'(bus.req0_ready), 1);
    chk("midrst req1_ready", W'(bus.req1_ready), 0);
    @(posedge clock); #1;
    chk("midrst first id", W'(bus.rsp_id), 0);

    // Randomized run against an in-order response queue model
    do_reset();
    q.delete();
    pri_m = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0;
    op0 = '0; a0 = '0; b0 = '0; op1 = '0; a1 = '0; b1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend0) begin
        pend0 = ($urandom_range(0, 3) != 0);
        op0 = OW'($urandom_range(0, 6)); a0 = $urandom; b0 = $urandom;
      end
      if (!pend1) begin
        pend1 = ($urandom_range(0, 3) != 0);
        op1 = OW'($urandom_range(0, 6)); a1 = $urandom; b1 = $urandom;
      end
      rr = ($urandom_range(0, 3) != 0);
      drive(pend0, op0, a0, b0, pend1, op1, a1, b1, rr);
      can = (q.size() == 0) || rr;
      er0 = can && pend0 && (!pend1 || !pri_m);
      er1 = can && pend1 && (!pend0 || pri_m);
      #1;
      chk($sformatf("rnd%0d req0_ready", c), W'(bus.req0_ready), W'(er0));
      chk($sformatf("rnd%0d req1_ready", c), W'(bus.req1_ready), W'(er1));
      check_alu($sformatf("rnd%0d", c), er0, er1, op0, a0, b0, op1, a1, b1);
      @(posedge clock); #1;
      if (q.size() != 0 && rr) void'(q.pop_front());
      if (er0) begin q.push_back('{id: 1'b0, d: alu_fn(op0, a0, b0)}); pend0 = 1'b0; pri_m = 1'b1; end
      if (er1) begin q.push_back('{id: 1'b1, d: alu_fn(op1, a1, b1)}); pend1 = 1'b0; pri_m = 1'b0; end
      chk($sformatf("rnd%0d rsp_valid", c), W'(bus.rsp_valid), W'(q.size() != 0));
      if (q.size() != 0) begin
        chk($sformatf("rnd%0d rsp_id", c), W'(bus.rsp_id), W'(q[0].id));
        chk($sformatf("rnd%0d rsp_data", c), bus.rsp_data, q[0].d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
